rgb_led_pwm_fader: RTL
======================

# rgb_led_pwm_fader

Downstream stage of the HPS system's four `rgb_led*_export` PIO outputs. It converts each of the 12 on/off colour-channel requests into a glitch-free PWM drive for the board RGB LEDs. Each channel can optionally fade linearly between off and full brightness instead of switching hard. The block sits in the top-level fabric between the HPS system instance and the LED pins.

## Interface
- `PWM_PRESCALE`, default 4: clock cycles per PWM counter step. Legal range 1..65535.
- `MAX_LEVEL`, default 255: brightness level a channel reaches when its request is 1. Legal range 1..255.
- `ACTIVE_LOW`, default 1: when 1, LED pins are driven low for "lit".
- `sys_clk_clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `sys_reset_reset` input, 1 bit: asynchronous, active-high reset. Deassertion is synchronised externally.
- `rgb_led0_export` … `rgb_led3_export` input, 3 bits each: per-LED requests, bit0=R, bit1=G, bit2=B. 1 means on. These are in the same clock domain.
- `fade_en` input, 1 bit: 1 selects ramping; 0 selects a hard switch at the next period boundary.
- `led_o` output, 12 bits: LED n, colour c maps to bit 3n+c. Registered.
- `ramp_busy` output, 1 bit: 1 while any channel level differs from its target. Registered.

## Operation
- Prescaler `presc` counts 0..PWM_PRESCALE-1. `step` is asserted when `presc`=PWM_PRESCALE-1, and `presc` then wraps to 0.
- PWM counter `pwm_cnt` is 8 bits and increments on `step`, wrapping 255→0.
- `period_end` is asserted when `step` and `pwm_cnt`=255.
- Per channel `target` = request bit ? MAX_LEVEL : 0. This is evaluated combinationally from the current request inputs.
- Per channel `level` is 8 bits and updates only on `period_end`:
  - `fade_en`=1: if level<target, level+1; if level>target, level−1; otherwise hold. The step is exactly 1 per period, with no overshoot or wrap.
  - `fade_en`=0: level ← target.
- Per channel `lit` = (level==255) OR (pwm_cnt < level). Level 0 is never lit. Level 255 is constantly lit.
- `led_o[i]` ← lit XOR ACTIVE_LOW, registered.
- `ramp_busy` ← OR over channels of (level≠target), registered.
- Request changes between period boundaries are ignored until the next `period_end`. Only the value present in the `period_end` cycle counts. Duty therefore never changes mid-period.
- A request toggled back before a ramp completes reverses direction at the next `period_end`. There is no restart from the end value.
- `fade_en` changing mid-ramp takes effect at the next `period_end`. A 0 there snaps the level to target.

## Timing
- Reset: `presc`=0, `pwm_cnt`=0, all levels=0. `led_o`=12'hFFF when ACTIVE_LOW=1, else 12'h000. `ramp_busy`=0.
- PWM period = 256×PWM_PRESCALE cycles.
- Latency:
  - A request sampled in a `period_end` cycle updates `level` on that edge.
  - `led_o` reflects the new level one cycle later, at `pwm_cnt`=0 of the new period.
  - `ramp_busy` rises one cycle after a request differs from the level, and falls one cycle after the last level reaches target.
- Full ramp 0→MAX_LEVEL with `fade_en`=1 takes MAX_LEVEL periods.
- Boundary cases:
  - `pwm_cnt` wrap and `period_end` fall in the same cycle. The level update and the counter wrap happen on the same edge.
  - With PWM_PRESCALE=1, `step` is asserted every cycle.
- Reset mid-ramp: all state and outputs return to their reset values immediately (asynchronously). There is no residual fade.

## Test plan
1. **Reset:** parameters PWM_PRESCALE=1, ACTIVE_LOW=1. Assert reset mid-operation → `led_o`=12'hFFF and `ramp_busy`=0 immediately; all levels are 0 after release.
2. **Hard switch:** `fade_en`=0, `rgb_led2_export`=3'b010. Then:
   - At the first `period_end`, bit 7 is driven to 0 (lit) one cycle later and stays 0 for all 256 cycles; the other bits stay 1.
   - `ramp_busy` pulses for the cycles until the boundary, then falls.
3. **Fade up:** `fade_en`=1, `rgb_led0_export`=3'b001, MAX_LEVEL=255. Then:
   - After k periods, bit 0 is lit for exactly k cycles per period, for k=1..254; it is constantly lit from period 255.
   - `ramp_busy` falls one cycle after level reaches 255.
4. **Reversal:** fade up for 10 periods, then clear the request → level goes 10→9→…→0 over 10 periods, with lit counts 9..0.
5. **Mid-period request change:** toggle a request for 20 cycles, not overlapping any `period_end` → no change on `led_o` and no change in level.
6. **MAX_LEVEL=128, PWM_PRESCALE=3:** request on with `fade_en`=0 → lit for 128×3=384 of 768 cycles per period.

Source files
------------

// File: rtl/rgb_led_pwm_fader.sv
// Purpose: turns 12 on/off colour requests into PWM LED drive, with optional linear fade.
// Latency: request sampled at period end -> level on that edge -> led_o one cycle later.
// Backpressure: none; free-running timer, requests only count in the period-end cycle.
module rgb_led_pwm_fader #(
    parameter int unsigned PWM_PRESCALE = 4,
    parameter int unsigned MAX_LEVEL    = 255,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset,
    input  logic [2:0]  rgb_led0_export,
    input  logic [2:0]  rgb_led1_export,
    input  logic [2:0]  rgb_led2_export,
    input  logic [2:0]  rgb_led3_export,
    input  logic        fade_en,
    output logic [11:0] led_o,
    output logic        ramp_busy
);

    localparam int          NCH        = 12;
    localparam int unsigned PW         = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);
    localparam logic [7:0]  MAX_L      = 8'(MAX_LEVEL);

    logic [PW-1:0]  presc;
    logic [7:0]     pwm_cnt;
    logic           step;
    logic           period_end;
    logic [NCH-1:0] req;
    logic [NCH-1:0] lit;
    logic [7:0]     target [NCH];
    logic [7:0]     level  [NCH];
    logic           busy_next;

    // LED n, colour c lands on bit 3n+c
    assign req        = {rgb_led3_export, rgb_led2_export, rgb_led1_export, rgb_led0_export};
    assign step       = (presc == PRESC_LAST);
    assign period_end = step && (pwm_cnt == 8'hFF);

    // Prescaler and 8-bit PWM counter; the counter wrap coincides with period_end
    always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
        if (sys_reset_reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else if (step) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc   <= presc + PW'(1);
        end
    end

    // Target brightness follows the live request inputs
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            target[i] = req[i] ? MAX_L : 8'd0;
        end
    end

    // Channel levels move only at period end so the duty never changes mid-period
    always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
        if (sys_reset_reset) begin
            for (int i = 0; i < NCH; i++) begin
                level[i] <= 8'd0;
            end
        end else if (period_end) begin
            for (int i = 0; i < NCH; i++) begin
                if (!fade_en) begin
                    level[i] <= target[i];
                end else if (level[i] < target[i]) begin
                    level[i] <= level[i] + 8'd1;
                end else if (level[i] > target[i]) begin
                    level[i] <= level[i] - 8'd1;
                end
            end
        end
    end

    // Duty comparison and ramp-in-progress detection; level 255 is held fully on
    always_comb begin
        lit       = '0;
        busy_next = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            lit[i]    = (level[i] == 8'hFF) || (pwm_cnt < level[i]);
            busy_next = busy_next | (level[i] != target[i]);
        end
    end

    // Registered pin drive and busy flag keep the outputs glitch-free
    always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
        if (sys_reset_reset) begin
            led_o     <= {NCH{ACTIVE_LOW}};
            ramp_busy <= 1'b0;
        end else begin
            led_o     <= lit ^ {NCH{ACTIVE_LOW}};
            ramp_busy <= busy_next;
        end
    end

endmodule
